pix_byte_unpack: RTL and testbench

//  Converts the UART byte stream into 12-bit RGB444 pixel writes for the frame RAM controller.

---
 rtl/pix_byte_unpack_pkg.sv | 14 +
 rtl/pix_blk_sum.sv | 68 ++++++
 rtl/pix_byte_unpack.sv | 162 ++++++++++++++++
 tb/tb_pix_byte_unpack.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pix_byte_unpack_pkg.sv
// Shared encodings and widths for the UART-to-RGB444 byte unpacker.
package pix_byte_unpack_pkg;
  localparam int RGB_W     = 12;
  localparam int PIX_CNT_W = 15;
  localparam int TO_CNT_W  = 19;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_DONE = 3'd4
  } pix_state_e;
endpackage

// File: rtl/pix_blk_sum.sv
// Block checksum: 8-bit wrapping byte sum with a per-block strobe and an end-of-frame flush.
module pix_blk_sum #(
  parameter int BLOCK_BYTES = 150
) (
  input  logic       i_clk_sys,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_add,
  input  logic [7:0] i_byte,
  input  logic       i_flush,
  output logic       o_nonzero,
  output logic [7:0] o_check_code,
  output logic       o_check_valid
);
  localparam int CNT_W = $clog2(BLOCK_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_BYTES - 1);

  logic [7:0]       sum_q, sum_d, sum_add;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       code_q, code_d;
  logic             vld_q, vld_d;

  // A clear that coincides with a byte restarts the block with that byte.
  always_comb begin
    sum_add = sum_q + i_byte;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    vld_d   = 1'b0;
    if (i_clr) begin
      sum_d = i_add ? i_byte : 8'h00;
      cnt_d = i_add ? CNT_W'(1) : '0;
    end else if (i_add) begin
      if (cnt_q == CNT_LAST) begin
        code_d = sum_add;
        vld_d  = 1'b1;
        sum_d  = 8'h00;
        cnt_d  = '0;
      end else begin
        sum_d = sum_add;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (i_flush && (cnt_q != '0)) begin
      code_d = sum_q;
      vld_d  = 1'b1;
      sum_d  = 8'h00;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q  <= 8'h00;
      cnt_q  <= '0;
      code_q <= 8'h00;
      vld_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      code_q <= code_d;
      vld_q  <= vld_d;
    end
  end

  assign o_nonzero     = (cnt_q != '0);
  assign o_check_code  = code_q;
  assign o_check_valid = vld_q;
endmodule

// File: rtl/pix_byte_unpack.sv
// Unpacks 3-byte groups from the UART into two RGB444 pixel writes, with per-block
// checksum, frame-end detection and an inter-byte stall timeout.
module pix_byte_unpack
  import pix_byte_unpack_pkg::*;
#(
  parameter int W           = 50,
  parameter int H           = 40,
  parameter int BLOCK_BYTES = 150,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic                 i_clk_sys,
  input  logic                 i_rst_n,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_enable,
  output logic [RGB_W-1:0]     o_pix,
  output logic                 o_pix_valid,
  output logic [PIX_CNT_W-1:0] o_pix_cnt,
  output logic [7:0]           o_check_code,
  output logic                 o_check_valid,
  output logic                 o_frame_done,
  output logic                 o_timeout_err,
  output logic                 o_busy
);
  localparam logic [PIX_CNT_W-1:0] LAST_IDX = PIX_CNT_W'(W * H - 1);
  localparam logic [TO_CNT_W-1:0]  TO_LIMIT = TO_CNT_W'(TIMEOUT_CYC);

  pix_state_e           state_q, state_d, grp_st;
  logic [7:0]           byte0_q, byte0_d;
  logic [3:0]           nib_q, nib_d;
  logic [RGB_W-1:0]     pix_q, pix_d;
  logic                 pix_valid_q, pix_valid_d;
  logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [PIX_CNT_W-1:0] blk_start_q, blk_start_d;
  logic                 frame_done_q, frame_done_d;
  logic                 to_err_q, to_err_d;
  logic [TO_CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic                 in_grp, counting, to_fire, byte_acc, frame_end, blk_clr, blk_nz;

  // A timeout behaves as if the group had restarted, so a same-cycle byte becomes byte0.
  always_comb begin
    in_grp    = (state_q == ST_B0) || (state_q == ST_B1) || (state_q == ST_B2);
    counting  = i_enable && in_grp &&
                ((state_q == ST_B1) || (state_q == ST_B2) || blk_nz);
    to_fire   = counting && (to_cnt_q == TO_LIMIT);
    grp_st    = to_fire ? ST_B0 : state_q;
    byte_acc  = i_enable && i_rx_done && in_grp;
    frame_end = (state_q == ST_DONE) && pix_valid_q;
    blk_clr   = to_fire || !i_enable;
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_B0;
        ST_B0, ST_B1, ST_B2: begin
          state_d = grp_st;
          if (i_rx_done) begin
            case (grp_st)
              ST_B0:   state_d = ST_B1;
              ST_B1:   state_d = ST_B2;
              default: state_d = (pix_cnt_q == LAST_IDX) ? ST_DONE : ST_B0;
            endcase
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    byte0_d      = byte0_q;
    nib_d        = nib_q;
    pix_d        = pix_q;
    pix_valid_d  = 1'b0;
    pix_cnt_d    = pix_cnt_q;
    blk_start_d  = blk_start_q;
    frame_done_d = frame_end;
    to_err_d     = to_err_q | to_fire;
    to_cnt_d     = (!counting || i_rx_done || to_fire) ? '0 : to_cnt_q + TO_CNT_W'(1);
    if (!i_enable) begin
      pix_cnt_d    = '0;
      blk_start_d  = '0;
      frame_done_d = 1'b0;
      to_err_d     = 1'b0;
    end else begin
      // The host resends the whole block after a stall, so rewind to its first pixel.
      if (to_fire)            pix_cnt_d   = blk_start_q;
      else if (o_check_valid) blk_start_d = pix_cnt_q;
      if (byte_acc) begin
        case (grp_st)
          ST_B0: byte0_d = i_rx_data;
          ST_B1: begin
            pix_d       = {byte0_q, i_rx_data[7:4]};
            nib_d       = i_rx_data[3:0];
            pix_valid_d = 1'b1;
            pix_cnt_d   = pix_cnt_q + PIX_CNT_W'(1);
          end
          default: begin
            pix_d       = {nib_q, i_rx_data};
            pix_valid_d = 1'b1;
            pix_cnt_d   = pix_cnt_q + PIX_CNT_W'(1);
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte0_q      <= 8'h00;
      nib_q        <= 4'h0;
      pix_q        <= '0;
      pix_valid_q  <= 1'b0;
      pix_cnt_q    <= '0;
      blk_start_q  <= '0;
      frame_done_q <= 1'b0;
      to_err_q     <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      byte0_q      <= byte0_d;
      nib_q        <= nib_d;
      pix_q        <= pix_d;
      pix_valid_q  <= pix_valid_d;
      pix_cnt_q    <= pix_cnt_d;
      blk_start_q  <= blk_start_d;
      frame_done_q <= frame_done_d;
      to_err_q     <= to_err_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  pix_blk_sum #(
    .BLOCK_BYTES(BLOCK_BYTES)
  ) u_blk_sum (
    .i_clk_sys    (i_clk_sys),
    .i_rst_n      (i_rst_n),
    .i_clr        (blk_clr),
    .i_add        (byte_acc),
    .i_byte       (i_rx_data),
    .i_flush      (frame_end),
    .o_nonzero    (blk_nz),
    .o_check_code (o_check_code),
    .o_check_valid(o_check_valid)
  );

  assign o_pix         = pix_q;
  assign o_pix_valid   = pix_valid_q;
  assign o_pix_cnt     = pix_cnt_q;
  assign o_frame_done  = frame_done_q;
  assign o_timeout_err = to_err_q;
  assign o_busy        = (state_q == ST_B1) || (state_q == ST_B2) || blk_nz;
endmodule

// File: tb/tb_pix_byte_unpack.sv
// Bench for pix_byte_unpack: table-driven frame plus scoreboarded multi-cycle corner cases.
module tb_pix_byte_unpack;
  import pix_byte_unpack_pkg::*;

  localparam int TO_CYC = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        en = 1'b0;

  logic [11:0] a_pix, b_pix;
  logic        a_pv, b_pv;
  logic [14:0] a_cnt, b_cnt;
  logic [7:0]  a_code, b_code;
  logic        a_cv, b_cv, a_fd, b_fd, a_err, b_err, a_busy, b_busy;

  always #5 clk = ~clk;

  pix_byte_unpack #(.W(4), .H(2), .BLOCK_BYTES(6), .TIMEOUT_CYC(TO_CYC)) dut_a (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_enable(en), .o_pix(a_pix), .o_pix_valid(a_pv), .o_pix_cnt(a_cnt),
    .o_check_code(a_code), .o_check_valid(a_cv), .o_frame_done(a_fd),
    .o_timeout_err(a_err), .o_busy(a_busy));

  pix_byte_unpack #(.W(4), .H(2), .BLOCK_BYTES(9), .TIMEOUT_CYC(TO_CYC)) dut_b (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_enable(en), .o_pix(b_pix), .o_pix_valid(b_pv), .o_pix_cnt(b_cnt),
    .o_check_code(b_code), .o_check_valid(b_cv), .o_frame_done(b_fd),
    .o_timeout_err(b_err), .o_busy(b_busy));

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [11:0] p0, p1;
  } vec_t;
  typedef struct {
    logic [11:0] pix;
    logic [14:0] cnt;
  } pexp_t;
  typedef struct {
    logic [7:0] code;
    logic       fd;
  } bexp_t;

  vec_t       tbl [4];
  pexp_t      pq[$];
  logic [7:0] cq[$];
  bexp_t      bq[$];

  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_cnt = 0;
  int         m_n = 0;
  logic [7:0] m_sum = 8'h00;
  logic       m_done = 1'b0;
  logic       b_mon = 1'b0;
  int         n_fd_a = 0;
  int         n_fd_b = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_cnt = 0;
    m_n     = 0;
    m_sum   = 8'h00;
    m_done  = 1'b0;
  endtask

  // Drives one byte strobe; the running block-sum model pushes expected check codes.
  task automatic send_byte(input logic [7:0] b);
    if (!m_done) begin
      m_sum = m_sum + b;
      m_n++;
      if (m_n == 6) begin
        cq.push_back(m_sum);
        m_sum = 8'h00;
        m_n   = 0;
      end
    end
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic exp_pix(input logic [11:0] p);
    pexp_t e;
    exp_cnt++;
    e.pix = p;
    e.cnt = 15'(exp_cnt);
    pq.push_back(e);
  endtask

  task automatic set_en(input logic v);
    @(posedge clk); #1;
    en = v;
    if (!v) model_reset();
    repeat (2) @(posedge clk);
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    pexp_t      pe;
    bexp_t      be;
    logic [7:0] ce;
    if (a_pv) begin
      if (pq.size() == 0) chk("pix_unexpected", 32'(a_pix), 32'hFFFF_FFFF);
      else begin
        pe = pq.pop_front();
        chk("pix", 32'(a_pix), 32'(pe.pix));
        chk("pix_cnt", 32'(a_cnt), 32'(pe.cnt));
      end
    end
    if (a_cv) begin
      if (cq.size() == 0) chk("check_unexpected", 32'(a_code), 32'hFFFF_FFFF);
      else begin
        ce = cq.pop_front();
        chk("check_code", 32'(a_code), 32'(ce));
      end
    end
    if (a_fd) n_fd_a++;
    if (b_mon && b_fd) n_fd_b++;
    if (b_mon && b_cv) begin
      if (bq.size() == 0) chk("b_check_unexpected", 32'(b_code), 32'hFFFF_FFFF);
      else begin
        be = bq.pop_front();
        chk("b_check_code", 32'(b_code), 32'(be.code));
        chk("b_check_with_frame_done", 32'(b_fd), 32'(be.fd));
      end
    end
  end

  initial begin
    bexp_t be;
    int    i;

    tbl[0] = '{b0: 8'hAB, b1: 8'hCD, b2: 8'hEF, p0: 12'hABC, p1: 12'hDEF};
    tbl[1] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, p0: 12'h000, p1: 12'h000};
    tbl[2] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, p0: 12'hFFF, p1: 12'hFFF};
    tbl[3] = '{b0: 8'h12, b1: 8'h34, b2: 8'h56, p0: 12'h123, p1: 12'h456};

    // Reset state
    #12;
    chk("rst_pix", 32'(a_pix), 32'h0);
    chk("rst_pix_valid", 32'(a_pv), 32'h0);
    chk("rst_pix_cnt", 32'(a_cnt), 32'h0);
    chk("rst_check", 32'({a_cv, a_code}), 32'h0);
    chk("rst_frame_done", 32'(a_fd), 32'h0);
    chk("rst_timeout_err", 32'(a_err), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven frame: 4 groups fill the 8-pixel frame
    set_en(1'b1);
    for (int k = 0; k < 4; k++) begin
      send_byte(tbl[k].b0);
      exp_pix(tbl[k].p0);
      send_byte(tbl[k].b1);
      exp_pix(tbl[k].p1);
      send_byte(tbl[k].b2);
    end
    m_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("frame1_done_count", 32'(n_fd_a), 32'd1);
    send_byte(8'h99);
    @(negedge clk);
    chk("done_pix_held", 32'(a_pix), 32'h456);
    chk("done_pix_cnt", 32'(a_cnt), 32'd8);
    chk("done_busy", 32'(a_busy), 32'h0);

    // Uniform frame: BLOCK_BYTES=6 gives two checks, BLOCK_BYTES=9 gives 0x09 then a flushed 0x03
    set_en(1'b0);
    set_en(1'b1);
    b_mon = 1'b1;
    be.code = 8'h09; be.fd = 1'b0; bq.push_back(be);
    be.code = 8'h03; be.fd = 1'b1; bq.push_back(be);
    for (int g = 0; g < 4; g++) begin
      send_byte(8'h01);
      exp_pix(12'h010);
      send_byte(8'h01);
      exp_pix(12'h101);
      send_byte(8'h01);
    end
    m_done = 1'b1;
    repeat (4) @(negedge clk);
    b_mon = 1'b0;
    chk("frame2_done_count", 32'(n_fd_a), 32'd2);
    chk("b_frame_done_count", 32'(n_fd_b), 32'd1);
    chk("b_checks_left", 32'(bq.size()), 32'd0);

    // Stall after two bytes of a group
    set_en(1'b0);
    set_en(1'b1);
    send_byte(8'h12);
    exp_pix(12'h123);
    send_byte(8'h34);
    i = 0;
    while (!a_err && i < TO_CYC + 50) begin
      @(negedge clk);
      i++;
    end
    model_reset();
    chk("timeout_err_set", 32'(a_err), 32'h1);
    chk("timeout_pix_cnt", 32'(a_cnt), 32'd0);
    chk("timeout_busy", 32'(a_busy), 32'h0);
    send_byte(8'hAA);
    exp_pix(12'hAAB);
    send_byte(8'hBB);
    exp_pix(12'hBCC);
    send_byte(8'hCC);
    send_byte(8'h01);
    exp_pix(12'h010);
    send_byte(8'h02);
    exp_pix(12'h203);
    send_byte(8'h03);
    send_byte(8'h44);
    exp_pix(12'h445);
    send_byte(8'h55);
    i = 0;
    while (a_busy && i < TO_CYC + 50) begin
      @(negedge clk);
      i++;
    end
    exp_cnt = 4;
    m_n     = 0;
    m_sum   = 8'h00;
    chk("rewind_busy", 32'(a_busy), 32'h0);
    chk("rewind_pix_cnt", 32'(a_cnt), 32'd4);
    chk("rewind_err_sticky", 32'(a_err), 32'h1);

    // Enable dropped mid-group
    send_byte(8'h55);
    set_en(1'b0);
    @(negedge clk);
    chk("disable_err_clear", 32'(a_err), 32'h0);
    chk("disable_pix_cnt", 32'(a_cnt), 32'd0);
    chk("disable_busy", 32'(a_busy), 32'h0);
    set_en(1'b1);
    send_byte(8'h11);
    exp_pix(12'h112);
    send_byte(8'h22);
    exp_pix(12'h233);
    send_byte(8'h33);

    // Asynchronous reset while waiting for byte2
    send_byte(8'h77);
    exp_pix(12'h778);
    send_byte(8'h88);
    @(negedge clk);
    chk("pre_rst_busy", 32'(a_busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pix", 32'(a_pix), 32'h0);
    chk("async_rst_pix_cnt", 32'(a_cnt), 32'h0);
    chk("async_rst_busy", 32'(a_busy), 32'h0);
    chk("async_rst_state", 32'(dut_a.state_q), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("pix_queue_empty", 32'(pq.size()), 32'd0);
    chk("check_queue_empty", 32'(cq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
